// File: rtl/bram_arbiter.sv
// bram_arbiter: two-master request/grant front end for the single-port RLS BRAM.
// Port 0 = RLS datapath, port 1 = host/coefficient loader.
//
// Ports:
//   clka, rst_n              clock, async active-low reset
//   reqN/weN/addrN/wdataN    per-master access request (N = 0,1)
//   lockN                    keep ownership for the next back-to-back access
//   gntN                     combinational grant; accepted when reqN & gntN
//   rvalidN/rdataN           read return for master N
//   bram_wea/addra/dina      registered RAM command
//   bram_douta               RAM read data
//
// Build option: BRAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins)
// instead of the default round-robin with lock.

module bram_arbiter #(
    parameter int unsigned AW           = 15,
    parameter int unsigned DW           = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          bram_wea,
    output logic [AW-1:0] bram_addra,
    output logic [DW-1:0] bram_dina,
    input  logic [DW-1:0] bram_douta
);

    localparam int unsigned RL = READ_LATENCY;

    logic          acc;
    logic          acc_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    assign acc      = (req0 & gnt0) | (req1 & gnt1);
    assign acc_id   = req1 & gnt1;
    assign sel_we   = acc_id ? we1    : we0;
    assign sel_addr = acc_id ? addr1  : addr0;
    assign sel_data = acc_id ? wdata1 : wdata0;

`ifdef BRAM_ARB_FIXED_PRIO_EN

    // lock1 only matters when port 0 is idle, where port 1 wins anyway,
    // so the locks carry no state in this build.
    assign gnt0 = req0;
    assign gnt1 = req1 & ~req0;

`else

    logic last;
    logic own;
    logic own_id;
    logic pick1;
    logic sel_lock;

    assign sel_lock = acc_id ? lock1 : lock0;

    always_comb begin
        pick1 = 1'b0;
        if (req0 & req1) begin
            if (own) pick1 = own_id;
            else     pick1 = ~last;
        end else begin
            pick1 = req1;
        end
    end

    assign gnt0 = req0 & ~pick1;
    assign gnt1 = req1 & pick1;

    // Ownership lasts exactly one cycle past a locked acceptance;
    // it is renewed only by another locked acceptance.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            last   <= 1'b1;
            own    <= 1'b0;
            own_id <= 1'b0;
        end else if (acc) begin
            last   <= acc_id;
            own    <= sel_lock;
            own_id <= acc_id;
        end else begin
            own    <= 1'b0;
        end
    end

`endif

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
        end else if (acc) begin
            bram_wea   <= sel_we;
            bram_addra <= sel_addr;
            bram_dina  <= sel_data;
        end else begin
            bram_wea   <= 1'b0;
        end
    end

    // Bit 0 is aligned with the registered command; the remaining RL
    // stages cover the RAM read latency.
    logic [RL:0] tag_v;
    logic [RL:0] tag_id;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[RL-1:0], acc & ~sel_we};
            tag_id <= {tag_id[RL-1:0], acc_id};
        end
    end

    assign rvalid0 = tag_v[RL] & ~tag_id[RL];
    assign rvalid1 = tag_v[RL] & tag_id[RL];
    assign rdata0  = bram_douta;
    assign rdata1  = bram_douta;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed per-cycle vector table for bram_arbiter
// plus hand-written reset sequences; behavioural 1-cycle BRAM model.

module tb_bram_arbiter;

    localparam int NV = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [14:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        bram_wea;
    logic [14:0] bram_addra;
    logic [31:0] bram_dina, bram_douta;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bram_arbiter dut (
        .clka(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .bram_wea(bram_wea), .bram_addra(bram_addra),
        .bram_dina(bram_dina), .bram_douta(bram_douta)
    );

    logic [31:0] mem [0:32767];
    always @(posedge clk) begin
        if (bram_wea) mem[bram_addra] <= bram_dina;
        bram_douta <= mem[bram_addra];
    end

    typedef struct {
        logic        r0, w0, l0;
        logic [14:0] a0;
        logic [31:0] d0;
        logic        r1, w1, l1;
        logic [14:0] a1;
        logic [31:0] d1;
        logic        g0, g1, rv0, rv1;
        logic [31:0] rd;
        logic        we, ca;
        logic [14:0] ea;
        logic [31:0] ed;
    } vec_t;

    vec_t tv [0:NV-1];

    task automatic rq(input int k, input int p, input logic w,
                      input logic [14:0] a, input logic [31:0] d,
                      input logic l);
        if (p == 0) begin
            tv[k].r0 = 1'b1; tv[k].w0 = w; tv[k].a0 = a;
            tv[k].d0 = d;    tv[k].l0 = l;
        end else begin
            tv[k].r1 = 1'b1; tv[k].w1 = w; tv[k].a1 = a;
            tv[k].d1 = d;    tv[k].l1 = l;
        end
    endtask

    // Expected effects of an access accepted in cycle k.
    task automatic ac(input int k, input int p, input logic w,
                      input logic [14:0] a, input logic [31:0] d,
                      input logic [31:0] rd);
        if (p == 0) tv[k].g0 = 1'b1;
        else        tv[k].g1 = 1'b1;
        tv[k+1].we = w;
        tv[k+1].ca = 1'b1;
        tv[k+1].ea = a;
        tv[k+1].ed = d;
        if (!w) begin
            if (p == 0) tv[k+2].rv0 = 1'b1;
            else        tv[k+2].rv1 = 1'b1;
            tv[k+2].rd = rd;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic fill();
        for (int k = 0; k < NV; k++) tv[k] = '{default: '0};
        // port 1 writes addr 0..9, data = addr
        for (int i = 0; i < 10; i++) begin
            rq(i, 1, 1'b1, 15'(i), 32'(i), 1'b0);
            ac(i, 1, 1'b1, 15'(i), 32'(i), 32'd0);
        end
        // port 0 reads them back
        for (int j = 0; j < 10; j++) begin
            rq(10 + j, 0, 1'b0, 15'(j), 32'd0, 1'b0);
            ac(10 + j, 0, 1'b0, 15'(j), 32'd0, 32'(j));
        end
        // port 1 read leaves port 1 as last served
        rq(20, 1, 1'b0, 15'd9, 32'd0, 1'b0);
        ac(20, 1, 1'b0, 15'd9, 32'd0, 32'd9);
        // continuous contention, no lock
        for (int i = 0; i < 8; i++) begin
            rq(22 + i, 0, 1'b0, 15'd3, 32'd0, 1'b0);
            rq(22 + i, 1, 1'b0, 15'd7, 32'd0, 1'b0);
`ifdef BRAM_ARB_FIXED_PRIO_EN
            ac(22 + i, 0, 1'b0, 15'd3, 32'd0, 32'd3);
`else
            if (i % 2 == 0) ac(22 + i, 0, 1'b0, 15'd3, 32'd0, 32'd3);
            else            ac(22 + i, 1, 1'b0, 15'd7, 32'd0, 32'd7);
`endif
        end
        // port 1 locks while port 0 waits
        for (int i = 0; i < 5; i++)
            rq(31 + i, 1, 1'b0, 15'd1, 32'd0, i < 4);
`ifdef BRAM_ARB_FIXED_PRIO_EN
        rq(32, 0, 1'b0, 15'd4, 32'd0, 1'b0);
        ac(31, 1, 1'b0, 15'd1, 32'd0, 32'd1);
        ac(32, 0, 1'b0, 15'd4, 32'd0, 32'd4);
        for (int i = 33; i < 36; i++)
            ac(i, 1, 1'b0, 15'd1, 32'd0, 32'd1);
`else
        for (int i = 32; i < 37; i++)
            rq(i, 0, 1'b0, 15'd4, 32'd0, 1'b0);
        for (int i = 31; i < 36; i++)
            ac(i, 1, 1'b0, 15'd1, 32'd0, 32'd1);
        rq(36, 1, 1'b0, 15'd1, 32'd0, 1'b0);
        rq(37, 1, 1'b0, 15'd1, 32'd0, 1'b0);
        ac(36, 0, 1'b0, 15'd4, 32'd0, 32'd4);
        ac(37, 1, 1'b0, 15'd1, 32'd0, 32'd1);
`endif
        // write then read of the same address
        rq(38, 0, 1'b1, 15'd5, 32'hDEADBEEF, 1'b0);
        ac(38, 0, 1'b1, 15'd5, 32'hDEADBEEF, 32'd0);
        rq(39, 1, 1'b0, 15'd5, 32'd0, 1'b0);
        ac(39, 1, 1'b0, 15'd5, 32'd0, 32'hDEADBEEF);
        // lock followed by an idle cycle releases ownership
        rq(43, 0, 1'b0, 15'd6, 32'd0, 1'b1);
        ac(43, 0, 1'b0, 15'd6, 32'd0, 32'd6);
        rq(45, 0, 1'b0, 15'd8, 32'd0, 1'b0);
        rq(45, 1, 1'b0, 15'd9, 32'd0, 1'b0);
`ifdef BRAM_ARB_FIXED_PRIO_EN
        ac(45, 0, 1'b0, 15'd8, 32'd0, 32'd8);
        rq(46, 1, 1'b0, 15'd9, 32'd0, 1'b0);
        ac(46, 1, 1'b0, 15'd9, 32'd0, 32'd9);
`else
        ac(45, 1, 1'b0, 15'd9, 32'd0, 32'd9);
        rq(46, 0, 1'b0, 15'd8, 32'd0, 1'b0);
        ac(46, 0, 1'b0, 15'd8, 32'd0, 32'd8);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic ok;
        fill();
        idle_in();
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wea",   32'(bram_wea),   32'd0);
        chk("rst_addra", 32'(bram_addra), 32'd0);
        chk("rst_dina",  bram_dina,       32'd0);
        chk("rst_rv",    32'({rvalid0, rvalid1}), 32'd0);
        chk("rst_gnt",   32'({gnt0, gnt1}), 32'b10);
        @(posedge clk); #1;
        idle_in();
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(posedge clk); #1;
            v = tv[k];
            req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0; lock0 = v.l0;
            req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1; lock1 = v.l1;
            @(negedge clk);
            ok = (gnt0 == v.g0) && (gnt1 == v.g1) &&
                 (rvalid0 == v.rv0) && (rvalid1 == v.rv1) &&
                 (bram_wea == v.we);
            if (v.rv0 && rdata0 !== v.rd) ok = 1'b0;
            if (v.rv1 && rdata1 !== v.rd) ok = 1'b0;
            if (v.ca && bram_addra !== v.ea) ok = 1'b0;
            if (v.we && bram_dina !== v.ed) ok = 1'b0;
            nvec++;
            if (!ok) begin
                nerr++;
                $display("FAIL vec%0d: gnt=%b%b rv=%b%b we=%b addr=%h din=%h rd0=%h rd1=%h; required gnt=%b%b rv=%b%b we=%b addr=%h din=%h rd=%h",
                         k, gnt0, gnt1, rvalid0, rvalid1, bram_wea, bram_addra,
                         bram_dina, rdata0, rdata1, v.g0, v.g1, v.rv0, v.rv1,
                         v.we, v.ea, v.ed, v.rd);
            end
        end

        // reset while a read is in flight
        @(posedge clk); #1;
        idle_in();
        req0  = 1'b1;
        addr0 = 15'd2;
        @(negedge clk);
        chk("mid_gnt0", 32'(gnt0), 32'd1);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("mid_addra", 32'(bram_addra), 32'd2);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rv",    32'({rvalid0, rvalid1}), 32'd0);
        chk("mid_wea",   32'(bram_wea),   32'd0);
        chk("mid_addra0", 32'(bram_addra), 32'd0);
        chk("mid_dina",  bram_dina,       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rv", 32'({rvalid0, rvalid1}), 32'd0);
        end

        // fresh read after reset
        @(posedge clk); #1;
        req0  = 1'b1;
        addr0 = 15'd3;
        @(negedge clk);
        chk("new_gnt", 32'({gnt0, gnt1}), 32'b10);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("new_addra", 32'(bram_addra), 32'd3);
        chk("new_rv_early", 32'({rvalid0, rvalid1}), 32'd0);
        @(negedge clk);
        chk("new_rv", 32'({rvalid0, rvalid1}), 32'b10);
        chk("new_rdata0", rdata0, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
